// File: rtl/sound_pwm_out.sv
// PWM speaker output stage: volume-scales the sample stream, latches duty only at
// period wraps, and soft-ramps the output level when sound is enabled or disabled.
module sound_pwm_out #(
    parameter int N         = 8,
    parameter int RAMP_STEP = 32
) (
    input  logic         clk,
    input  logic         nRst,
    input  logic [N-1:0] sample_i,
    input  logic [2:0]   volume_i,
    input  logic         enable_i,
    output logic         pwm_o,
    output logic         period_start_o,
    output logic         active_o,
    output logic [1:0]   state_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        ACTIVE    = 2'd2,
        RAMP_DOWN = 2'd3
    } state_e;

    localparam logic [N-1:0] MAX  = {N{1'b1}};
    localparam logic [N:0]   STEP = (N+1)'(RAMP_STEP);

    state_e       state_q, state_d;
    logic [N-1:0] cnt_q;
    logic [N-1:0] ramp_q;
    logic [N-1:0] duty_q;
    logic         pwm_q;
    logic         pstart_q;

    logic         wrap;
    logic [3:0]   vol_mul;
    logic [N+2:0] product;
    logic [N-1:0] scaled;
    logic [N:0]   ramp_sum;
    logic [N-1:0] ramp_up_sat;
    logic [N-1:0] ramp_dn_sat;
    logic [N-1:0] ramp_next;
    logic [N-1:0] duty_next;
    logic [N:0]   ramp_diff;

    assign wrap = (cnt_q == MAX);

    // volume 7 multiplies by 8 and the >>3 gives back the sample unchanged
    assign vol_mul = {1'b0, volume_i} + 4'd1;
    assign product = {3'b000, sample_i} * {{(N-1){1'b0}}, vol_mul};
    assign scaled  = product[N+2:3];

    assign ramp_sum    = {1'b0, ramp_q} + STEP;
    assign ramp_diff   = {1'b0, ramp_q} - STEP;
    assign ramp_up_sat = (ramp_sum > {1'b0, MAX}) ? MAX : ramp_sum[N-1:0];
    assign ramp_dn_sat = ({1'b0, ramp_q} < STEP) ? '0 : ramp_diff[N-1:0];
    assign ramp_next   = enable_i ? ramp_up_sat : ramp_dn_sat;
    assign duty_next   = (scaled < ramp_next) ? scaled : ramp_next;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (wrap) begin
            if (ramp_next == '0) begin
                state_d = IDLE;
            end else if (ramp_next == MAX) begin
                state_d = ACTIVE;
            end else if (enable_i) begin
                state_d = RAMP_UP;
            end else begin
                state_d = RAMP_DOWN;
            end
        end
    end

    always_comb begin
        active_o = (state_q != IDLE);
        state_o  = state_q;
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            cnt_q    <= '0;
            ramp_q   <= '0;
            duty_q   <= '0;
            pwm_q    <= 1'b0;
            pstart_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_q + 1'b1;
            pwm_q    <= (cnt_q < duty_q);
            pstart_q <= wrap;
            if (wrap) begin
                ramp_q <= ramp_next;
                duty_q <= duty_next;
            end
        end
    end

    assign pwm_o          = pwm_q;
    assign period_start_o = pstart_q;

endmodule

// File: tb/tb_sound_pwm_out.sv
// Directed bench for sound_pwm_out: ramp up/down, volume scaling, mid-period
// input changes, direction reversal and asynchronous reset mid-period.
module tb_sound_pwm_out;

    localparam int N = 8;
    localparam logic [31:0] S_IDLE = 0;
    localparam logic [31:0] S_UP   = 1;
    localparam logic [31:0] S_ACT  = 2;
    localparam logic [31:0] S_DN   = 3;

    logic         clk;
    logic         nRst;
    logic [N-1:0] sample_i;
    logic [2:0]   volume_i;
    logic         enable_i;
    logic         pwm_o;
    logic         period_start_o;
    logic         active_o;
    logic [1:0]   state_o;

    int checks = 0;
    int errors = 0;

    sound_pwm_out #(.N(N), .RAMP_STEP(32)) dut (
        .clk            (clk),
        .nRst           (nRst),
        .sample_i       (sample_i),
        .volume_i       (volume_i),
        .enable_i       (enable_i),
        .pwm_o          (pwm_o),
        .period_start_o (period_start_o),
        .active_o       (active_o),
        .state_o        (state_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Called at the negedge where period_start_o is high; counts pwm_o over the
    // following 256 negedges, which cover pwm_cnt 0..255 of that period.
    task automatic measure(input string tag, input int exp_hi, input bit poke);
        int hi;
        int ps;
        hi = 0;
        ps = 0;
        chk({tag, "_start"}, {31'd0, period_start_o}, 32'd1);
        for (int k = 1; k <= 256; k++) begin
            @(negedge clk);
            if (pwm_o === 1'b1) hi++;
            if (period_start_o === 1'b1) ps++;
            if (poke && k == 100) begin
                enable_i = ~enable_i;
                sample_i = 8'd255;
            end
            if (poke && k == 200) begin
                enable_i = ~enable_i;
                sample_i = 8'd200;
            end
        end
        chk({tag, "_hi"}, hi, exp_hi);
        chk({tag, "_pstart_once"}, ps, 1);
    endtask

    task automatic check_state(input string tag, input logic [31:0] exp_s);
        chk({tag, "_state"}, {30'd0, state_o}, exp_s);
        chk({tag, "_active"}, {31'd0, active_o}, (exp_s != S_IDLE) ? 32'd1 : 32'd0);
    endtask

    // Counts negedges from reset release to the first period_start_o, bounded.
    task automatic first_start(input string tag);
        int n;
        int hi;
        n  = 0;
        hi = 0;
        do begin
            @(negedge clk);
            n++;
            if (pwm_o === 1'b1) hi++;
        end while (period_start_o !== 1'b1 && n < 600);
        chk({tag, "_latency"}, n, 256);
        chk({tag, "_quiet"}, hi, 0);
    endtask

    int up_duty[8]   = '{32, 64, 96, 128, 160, 192, 200, 200};
    int dn_duty[8]   = '{200, 191, 159, 127, 95, 63, 31, 0};
    int rev_duty[4]  = '{64, 32, 64, 96};
    int rise_duty[4] = '{128, 160, 192, 200};

    initial begin
        nRst     = 1'b0;
        enable_i = 1'b1;
        sample_i = 8'd200;
        volume_i = 3'd7;
        repeat (3) @(negedge clk);
        chk("rst_pwm", {31'd0, pwm_o}, 0);
        chk("rst_pstart", {31'd0, period_start_o}, 0);
        check_state("rst", S_IDLE);

        nRst = 1'b1;
        first_start("boot");

        // Ramp up
        for (int i = 0; i < 8; i++) begin
            check_state($sformatf("up%0d", i), (i == 7) ? S_ACT : S_UP);
            measure($sformatf("up%0d", i), up_duty[i], 1'b0);
        end

        // Volume scaling
        volume_i = 3'd3;
        measure("vol7_hold", 200, 1'b0);
        measure("vol3", 100, 1'b0);
        volume_i = 3'd0;
        measure("vol3_hold", 100, 1'b0);
        measure("vol0", 25, 1'b0);
        volume_i = 3'd7;
        sample_i = 8'd255;
        measure("vol0_hold", 25, 1'b0);
        measure("full255", 255, 1'b0);
        sample_i = 8'd200;
        measure("full255_hold", 255, 1'b0);

        // Mid-period changes of enable/sample have no effect
        check_state("mid_pre", S_ACT);
        measure("mid_cur", 200, 1'b1);
        check_state("mid_post", S_ACT);
        measure("mid_next", 200, 1'b0);

        // Ramp down
        enable_i = 1'b0;
        measure("dn_pre", 200, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check_state($sformatf("dn%0d", i), (i == 7) ? S_IDLE : S_DN);
            measure($sformatf("dn%0d", i), dn_duty[i], 1'b0);
        end
        check_state("idle_after", S_IDLE);
        measure("idle_low", 0, 1'b0);

        // Reversal: up to 96, down twice, then up again
        enable_i = 1'b1;
        measure("rev_idle", 0, 1'b0);
        check_state("rev_a", S_UP);
        measure("rev_32", 32, 1'b0);
        check_state("rev_b", S_UP);
        measure("rev_64", 64, 1'b0);
        check_state("rev_c", S_UP);
        enable_i = 1'b0;
        measure("rev_96", 96, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check_state($sformatf("rev_r%0d", i), (i < 2) ? S_DN : S_UP);
            if (i == 1) enable_i = 1'b1;
            measure($sformatf("rev_r%0d", i), rev_duty[i], 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            check_state($sformatf("rise%0d", i), S_UP);
            measure($sformatf("rise%0d", i), rise_duty[i], 1'b0);
        end
        check_state("rise_done", S_ACT);

        // Asynchronous reset mid-period while ACTIVE
        repeat (50) @(negedge clk);
        chk("pre_rst_pwm", {31'd0, pwm_o}, 1);
        #2;
        nRst = 1'b0;
        #1;
        chk("async_pwm", {31'd0, pwm_o}, 0);
        chk("async_pstart", {31'd0, period_start_o}, 0);
        check_state("async", S_IDLE);
        @(negedge clk);
        nRst = 1'b1;
        first_start("rerun");
        check_state("rerun_first", S_UP);
        measure("rerun_32", 32, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
